cpp_internal_bool_to_double_convert: RTL and testbench

CPP_INTERNAL_BOOL_TO_DOUBLE_CONVERT -- requirements
Module: cpp_internal_bool_to_double_convert

---
 rtl/cpp_internal_bool_to_double_convert.sv | 93 +++++++++
 tb/tb_cpp_internal_bool_to_double_convert.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpp_internal_bool_to_double_convert.sv
`default_nettype none
// ============================================================================
// Module   : cpp_internal_bool_to_double_convert
// Brief    : Ramps a boolean level into an IEEE-754 double, one step per
//            update_in edge, over 2^RAMP_LOG2 steps between 0.0 and 1.0.
// Revision : 1.0 - initial release
// ============================================================================
module cpp_internal_bool_to_double_convert #(
  parameter int RAMP_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in,
  input  logic        update_in,
  output logic [63:0] out,
  output logic        update_out,
  output logic        busy
);

  localparam int KW = RAMP_LOG2 + 1;
  localparam logic [KW-1:0] K_MAX = KW'(1) << RAMP_LOG2;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [63:0]     out_q, out_d;
  logic            busy_q, busy_d;
  logic            update_in_q, update_in_d;
  logic            upd_event;

  // k/2^RAMP_LOG2 is a dyadic fraction, so the double is exact: the leading
  // one becomes the hidden bit and the remaining bits of k fill the mantissa.
  function automatic logic [63:0] encode(input logic [KW-1:0] k);
    logic [63:0] kx;
    logic [51:0] mant;
    logic [10:0] expo;
    int          p;
    p = 0;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) p = i;
    end
    kx   = 64'(k);
    mant = 52'(kx << (52 - p));
    expo = 11'(1023 + p - RAMP_LOG2);
    encode = (k == '0) ? 64'h0 : {1'b0, expo, mant};
  endfunction

  always_comb begin
    k_d         = k_q;
    state_d     = state_q;
    update_in_d = update_in;
    upd_event   = update_in ^ update_in_q;
    if (upd_event) begin
      if (in && (k_q != K_MAX)) begin
        k_d     = k_q + 1'b1;
        state_d = (k_d == K_MAX) ? ST_HIGH : ST_RISING;
      end else if (!in && (k_q != '0)) begin
        k_d     = k_q - 1'b1;
        state_d = (k_d == '0) ? ST_LOW : ST_FALLING;
      end
    end
    out_d  = encode(k_d);
    busy_d = (k_d != '0) && (k_d != K_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOW;
      k_q         <= '0;
      out_q       <= 64'h0;
      busy_q      <= 1'b0;
      update_in_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      update_in_q <= update_in_d;
    end
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign update_out = update_in_q;

endmodule
`default_nettype wire

// File: tb/tb_cpp_internal_bool_to_double_convert.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpp_internal_bool_to_double_convert
// Brief    : Scoreboard bench for the bool-to-double ramp, two ramp lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpp_internal_bool_to_double_convert;

  typedef struct packed {
    logic [63:0] o;
    logic        b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in = 1'b0;
  logic        update_in = 1'b0;
  logic [63:0] out2, out0;
  logic        update_out2, update_out0;
  logic        busy2, busy0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   k2 = 0;
  int   k0 = 0;
  exp_t q2[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  cpp_internal_bool_to_double_convert #(.RAMP_LOG2(2)) u_dut2 (
    .clk(clk), .reset(reset), .in(in), .update_in(update_in),
    .out(out2), .update_out(update_out2), .busy(busy2)
  );

  cpp_internal_bool_to_double_convert #(.RAMP_LOG2(0)) u_dut0 (
    .clk(clk), .reset(reset), .in(in), .update_in(update_in),
    .out(out0), .update_out(update_out0), .busy(busy0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: level is the fraction k/steps, saturating at 0 and 1.
  function automatic exp_t expect_of(input int k, input int steps);
    exp_t e;
    e.o = $realtobits(real'(k) / real'(steps));
    e.b = (k > 0) && (k < steps);
    return e;
  endfunction

  task automatic step_models(input logic lvl);
    if (lvl) begin
      if (k2 < 4) k2++;
      if (k0 < 1) k0++;
    end else begin
      if (k2 > 0) k2--;
      if (k0 > 0) k0--;
    end
    q2.push_back(expect_of(k2, 4));
    q0.push_back(expect_of(k0, 1));
  endtask

  task automatic ev(input logic lvl);
    @(negedge clk);
    in = lvl;
    update_in = ~update_in;
    step_models(lvl);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in = 1'($urandom_range(0, 1));
    @(posedge clk);
  endtask

  task automatic do_reset(input logic upd_level, input logic lvl);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_out2", out2, 64'h0);
    chk("rst_busy2", 64'(busy2), 64'h0);
    chk("rst_uo2", 64'(update_out2), 64'h0);
    chk("rst_out0", out0, 64'h0);
    chk("rst_uo0", 64'(update_out0), 64'h0);
    k2 = 0;
    k0 = 0;
    update_in = upd_level;
    in = lvl;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    if (upd_level) step_models(lvl);
    @(posedge clk);
  endtask

  // Monitor: a toggle of update_out marks a completed event; otherwise the
  // outputs must hold their last value.
  exp_t last2 = '0;
  exp_t last0 = '0;
  logic prev_uo2 = 1'b0;
  logic prev_uo0 = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      prev_uo2 = 1'b0;
      prev_uo0 = 1'b0;
      last2    = '0;
      last0    = '0;
    end else begin
      if (update_out2 !== prev_uo2) begin
        if (q2.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL r2_unexpected_event: got update_out %b expected no toggle", update_out2);
        end else begin
          e = q2.pop_front();
          chk("r2_out", out2, e.o);
          chk("r2_busy", 64'(busy2), 64'(e.b));
          chk("r2_update_out", 64'(update_out2), 64'(update_in));
          last2 = e;
        end
      end else begin
        chk("r2_hold_out", out2, last2.o);
        chk("r2_hold_busy", 64'(busy2), 64'(last2.b));
      end
      if (update_out0 !== prev_uo0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL r0_unexpected_event: got update_out %b expected no toggle", update_out0);
        end else begin
          e = q0.pop_front();
          chk("r0_out", out0, e.o);
          chk("r0_busy", 64'(busy0), 64'(e.b));
          chk("r0_update_out", 64'(update_out0), 64'(update_in));
          last0 = e;
        end
      end else begin
        chk("r0_hold_out", out0, last0.o);
        chk("r0_hold_busy", 64'(busy0), 64'(last0.b));
      end
      prev_uo2 = update_out2;
      prev_uo0 = update_out0;
    end
  end

  initial begin
    #2;
    chk("init_out2", out2, 64'h0);
    chk("init_busy2", 64'(busy2), 64'h0);
    chk("init_uo2", 64'(update_out2), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Full rising ramp, then saturation at 1.0
    repeat (4) ev(1'b1);
    ev(1'b1);

    // Reversal mid-ramp
    do_reset(1'b0, 1'b0);
    ev(1'b1);
    ev(1'b1);
    ev(1'b0);

    // in wiggling with no update edges
    repeat (10) idle();

    // Reset abandons a ramp at k=3; next rising event restarts from 0
    ev(1'b1);
    ev(1'b1);
    do_reset(1'b0, 1'b0);
    ev(1'b1);

    // update_in already high at release counts as an event
    do_reset(1'b1, 1'b1);

    // Randomized traffic with runs of same-direction events
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        idle();
      end else if (r < 10) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        logic lvl;
        lvl = 1'($urandom_range(0, 1));
        repeat (int'($urandom_range(1, 6))) ev(lvl);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("q2_drained", 64'(q2.size()), 64'h0);
    chk("q0_drained", 64'(q0.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
